prog_loader: RTL and testbench

- Byte-stream program loader. It is the writing end of the 8-bit program memory port that the CPU core reads during its two-cycle instruction fetch.
- It accepts a framed program image over a valid/ready byte interface and writes it into the memory, high instruction byte first.
- It holds the CPU in reset while loading and releases it only after a frame passes its checksum.

---
 rtl/prog_loader.sv | 182 ++++++++++++++++++
 tb/tb_prog_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader driving the write side of the
// 8-bit program memory. Frames are LEN, 2*LEN payload bytes (instruction
// high byte first), then an XOR checksum of the payload. The CPU is held
// in reset until a frame checks out.
//
// Optional feature: define LOADER_TIMEOUT_EN to abort a frame into the
// error state after TIMEOUT_CYCLES busy cycles without an accepted byte.
//
// Handshake: a byte transfers in every cycle where in_valid && in_ready.
// in_ready depends only on the state register, never on in_valid, and
// in_data is ignored whenever in_valid is low.
module prog_loader #(
    parameter logic [7:0] BASE_ADDR      = 8'h00,
    parameter int         MAX_WORDS      = 128,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [7:0] mem_address,
    output logic       mem_write_enable,
    output logic [7:0] mem_write_data,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [7:0] words_loaded,
    output logic [2:0] state_dbg
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LEN  = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_CHK  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR  = 3'd6;

    localparam logic [8:0] MAX_LEN = MAX_WORDS[8:0];

    logic [2:0] state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] words_q, words_d;
    logic [7:0] next_addr_q, next_addr_d;
    logic [7:0] acc_q, acc_d;
    logic       mem_we_q, mem_we_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_data_q, mem_data_d;
    logic       release_q, release_d;
    logic       accept;
    logic       busy_s;

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
`endif

    assign busy_s           = (state_q == S_LEN) || (state_q == S_HI) ||
                              (state_q == S_LO)  || (state_q == S_CHK);
    assign accept           = in_valid && busy_s;

    assign in_ready         = busy_s;
    assign busy             = busy_s;
    assign done             = (state_q == S_DONE);
    assign error            = (state_q == S_ERR);
    // Released only once the loader has sat in DONE for a full cycle.
    assign cpu_reset        = !release_q;
    assign mem_address      = mem_addr_q;
    assign mem_write_enable = mem_we_q;
    assign mem_write_data   = mem_data_q;
    assign words_loaded     = words_q;
    assign state_dbg        = state_q;

    // Next-state, payload write and checksum logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        words_d     = words_q;
        next_addr_d = next_addr_q;
        acc_d       = acc_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN;
                    words_d     = 8'h00;
                    next_addr_d = BASE_ADDR;
                    acc_d       = 8'h00;
                end
            end
            S_LEN: begin
                if (accept) begin
                    if (in_data == 8'h00 || {1'b0, in_data} > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = in_data;
                        state_d = S_HI;
                    end
                end
            end
            S_HI, S_LO: begin
                if (accept) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = next_addr_q;
                    mem_data_d  = in_data;
                    next_addr_d = next_addr_q + 8'd1;
                    acc_d       = acc_q ^ in_data;
                    if (state_q == S_HI) begin
                        state_d = S_LO;
                    end else begin
                        words_d = words_q + 8'd1;
                        state_d = (words_q + 8'd1 == len_q) ? S_CHK : S_HI;
                    end
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (in_data == acc_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef LOADER_TIMEOUT_EN
        // Any busy cycle without a byte counts towards the timeout; the
        // count restarts on every accepted byte and whenever not busy.
        idle_cnt_d = '0;
        if (busy_s && !accept) begin
            if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_ERR;
            end else begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end
`endif

        release_d = (state_q == S_DONE) && (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= 8'h00;
            words_q     <= 8'h00;
            next_addr_q <= BASE_ADDR;
            acc_q       <= 8'h00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_data_q  <= 8'h00;
            release_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            words_q     <= words_d;
            next_addr_q <= next_addr_d;
            acc_q       <= acc_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            release_q   <= release_d;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    // Idle-cycle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: two instances (base 00 and base FE) share one
// stimulus stream; each has its own expected-write queue.
module tb_prog_loader;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_HI   = 3'd2;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_ERR  = 3'd6;

  logic       clk, reset, start, in_valid;
  logic [7:0] in_data;

  logic       in_ready_a, we_a, cpu_reset_a, busy_a, done_a, error_a;
  logic [7:0] addr_a, wdata_a, words_a;
  logic [2:0] state_a;
  logic       in_ready_b, we_b, cpu_reset_b, busy_b, done_b, error_b;
  logic [7:0] addr_b, wdata_b, words_b;
  logic [2:0] state_b;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];
  logic [7:0]  ptr_a, ptr_b;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  prog_loader #(.BASE_ADDR(8'h00), .MAX_WORDS(128), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_a), .mem_address(addr_a), .mem_write_enable(we_a),
    .mem_write_data(wdata_a), .cpu_reset(cpu_reset_a), .busy(busy_a), .done(done_a),
    .error(error_a), .words_loaded(words_a), .state_dbg(state_a)
  );

  prog_loader #(.BASE_ADDR(8'hFE), .MAX_WORDS(128), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_b), .mem_address(addr_b), .mem_write_enable(we_b),
    .mem_write_data(wdata_b), .cpu_reset(cpu_reset_b), .busy(busy_b), .done(done_b),
    .error(error_b), .words_loaded(words_b), .state_dbg(state_b)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && we_a) begin
      if (exp_q_a.size() == 0) chk("a_unexpected_write", {addr_a, wdata_a}, 16'hxxxx);
      else chk("a_write", {addr_a, wdata_a}, exp_q_a.pop_front());
    end
    if (!reset && we_b) begin
      if (exp_q_b.size() == 0) chk("b_unexpected_write", {addr_b, wdata_b}, 16'hxxxx);
      else chk("b_write", {addr_b, wdata_b}, exp_q_b.pop_front());
    end
  end

  task automatic chk_status(input string tag, input logic [2:0] st, input logic dn,
                            input logic er, input logic cr, input logic [7:0] wl);
    chk({tag, "_state_a"}, state_a, st);
    chk({tag, "_state_b"}, state_b, st);
    chk({tag, "_done"}, {done_a, done_b}, {dn, dn});
    chk({tag, "_error"}, {error_a, error_b}, {er, er});
    chk({tag, "_cpu_reset"}, {cpu_reset_a, cpu_reset_b}, {cr, cr});
    chk({tag, "_words"}, {words_a, words_b}, {wl, wl});
  endtask

  task automatic chk_reset_values(input string tag);
    chk_status(tag, S_IDLE, 1'b0, 1'b0, 1'b1, 8'h00);
    chk({tag, "_in_ready"}, {in_ready_a, in_ready_b}, 2'b00);
    chk({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
    chk({tag, "_we"}, {we_a, we_b}, 2'b00);
    chk({tag, "_addr"}, {addr_a, addr_b}, 16'h00FE);
    chk({tag, "_wdata"}, {wdata_a, wdata_b}, 16'h0000);
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ptr_a = 8'h00;
    ptr_b = 8'hFE;
    chk("start_busy", {busy_a, busy_b, cpu_reset_a, cpu_reset_b}, 4'b1111);
  endtask

  // Present one byte, wait (bounded) for acceptance, then check the write
  // strobe in the cycle right after the accepting edge.
  task automatic send(input logic [7:0] b, input bit payload);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready_a && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd0, 32'd1);
    if (payload) begin
      exp_q_a.push_back({ptr_a, b});
      exp_q_b.push_back({ptr_b, b});
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom_range(0, 255));
    if (payload) begin
      chk("write_latency", {we_a, we_b, addr_a, addr_b, wdata_a, wdata_b},
          {2'b11, ptr_a, ptr_b, b, b});
      ptr_a = ptr_a + 8'd1;
      ptr_b = ptr_b + 8'd1;
    end else begin
      chk("no_write_len_chk", {we_a, we_b}, 2'b00);
    end
  endtask

  // Idle cycles with garbage data: state and outputs must hold still.
  task automatic gap(input int cycles);
    logic [2:0] st;
    st = state_a;
    for (int i = 0; i < cycles; i++) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom_range(0, 255));
      @(posedge clk); #1;
      chk("gap_state", state_a, st);
      chk("gap_no_write", {we_a, we_b}, 2'b00);
    end
  endtask

  task automatic send_frame(input logic [7:0] len, input logic [7:0] p0, input logic [7:0] p1,
                            input logic [7:0] p2, input logic [7:0] p3, input logic [7:0] ck);
    pulse_start();
    send(len, 1'b0);
    send(p0, 1'b1);
    send(p1, 1'b1);
    if (len == 8'd2) begin
      send(p2, 1'b1);
      send(p3, 1'b1);
    end
    send(ck, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    ptr_a = 8'h00; ptr_b = 8'hFE;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Good two-word frame.
    send_frame(8'h02, 8'h1A, 8'h05, 8'hD0, 8'h00, 8'hCF);
    chk_status("good_first_done_cycle", S_DONE, 1'b1, 1'b0, 1'b1, 8'd2);
    @(posedge clk); #1;
    chk_status("good_released", S_DONE, 1'b1, 1'b0, 1'b0, 8'd2);
    chk("good_idle_outputs", {busy_a, in_ready_a, busy_b, in_ready_b}, 4'b0000);

    // Same frame with a wrong checksum.
    send_frame(8'h02, 8'h1A, 8'h05, 8'hD0, 8'h00, 8'h00);
    @(posedge clk); #1;
    chk_status("bad_chk", S_ERR, 1'b0, 1'b1, 1'b1, 8'd2);

    // Illegal lengths.
    pulse_start();
    send(8'h00, 1'b0);
    chk_status("len_zero", S_ERR, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("len_zero_ready", {in_ready_a, in_ready_b}, 2'b00);
    pulse_start();
    send(8'h81, 1'b0);
    chk_status("len_129", S_ERR, 1'b0, 1'b1, 1'b1, 8'd0);
    chk("len_129_ready", {in_ready_a, in_ready_b}, 2'b00);

    // Frame whose addresses wrap on the FE instance.
    send_frame(8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
    chk_status("wrap_done", S_DONE, 1'b1, 1'b0, 1'b1, 8'd2);

    // One-word frame with back-pressure gaps.
    pulse_start();
    send(8'h01, 1'b0);
    gap(2);
    send(8'hD0, 1'b1);
    gap(1);
    send(8'h00, 1'b1);
    gap(1);
    send(8'hD0, 1'b0);
    @(posedge clk); #1;
    chk_status("gap_done", S_DONE, 1'b1, 1'b0, 1'b0, 8'd1);

    // Start while busy is ignored, then reset during HI.
    pulse_start();
    send(8'h02, 1'b0);
    chk("in_hi", state_a, S_HI);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_while_busy", state_a, S_HI);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_values("mid_frame_reset");
    reset = 1'b0;
    @(posedge clk); #1;

`ifdef LOADER_TIMEOUT_EN
    pulse_start();
    send(8'h01, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    chk("timeout_not_yet", {error_a, busy_a}, 2'b01);
    @(posedge clk); #1;
    chk("timeout_err", {error_a, busy_a, error_b, busy_b}, 4'b1010);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("queue_a_drained", exp_q_a.size(), 0);
    chk("queue_b_drained", exp_q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

endmodule
